fir_delay_rf: RTL

Parametrised multi-channel register file for the FIR datapath, the successor to the single-channel 64x16 coefficient/sample store. Each channel can run in linear mode (random-access coefficient storage) or circular mode (delay line with per-channel head pointer, addressed by tap offset). Reads are registered on clk2 with a qualifying valid. The FIR run controller sits on the read side; the sample ingress and config loaders sit on the write side.

---
 rtl/fir_delay_rf.sv | 85 ++++++++
 1 files changed

// File: rtl/fir_delay_rf.sv
// fir_delay_rf: multi-channel FIR register file with per-channel linear or circular (delay line) addressing.
// Define FIR_DELAY_RF_WR_FWD_EN for write-first forwarding on same-address read/write collisions.
module fir_delay_rf #(
  parameter int DEPTH  = 64,
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 6,
  parameter int NCH    = 2,
  parameter int CH_W   = 1
) (
  input  logic                     clk2,
  input  logic                     rst,
  input  logic [NCH-1:0]           mode,
  input  logic                     wr_en,
  input  logic [CH_W-1:0]          wr_ch,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic signed [WIDTH-1:0]  wr_data,
  input  logic                     rd_en,
  input  logic [CH_W-1:0]          rd_ch,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic signed [WIDTH-1:0]  rd_data,
  output logic                     rd_valid,
  input  logic                     clr_en,
  input  logic [CH_W-1:0]          clr_ch,
  output logic [NCH-1:0]           full
);
  localparam int NSLOT = 2 ** CH_W;
  localparam logic [ADDR_W:0] FULL_FILL = (ADDR_W + 1)'(DEPTH);
  function automatic logic [NSLOT-1:0] ok_mask();
    for (int i = 0; i < NSLOT; i++) ok_mask[i] = i < NCH;
  endfunction
  // Channel-select encodings beyond NCH-1 are reserved and treated as absent channels
  localparam logic [NSLOT-1:0] CH_OK = ok_mask();
  logic signed [WIDTH-1:0] mem [NCH*DEPTH];
  logic [ADDR_W-1:0] head [NCH];
  logic [ADDR_W:0] fill [NCH];
  logic wr_ok, rd_ok, clr_ok, wr_circ, rd_circ, wr_clr, rd_zero;
  logic [ADDR_W-1:0] wr_pa, rd_pa;
  logic [ADDR_W:0] wr_fill;
  logic signed [WIDTH-1:0] rd_word;
  always_comb begin
    wr_ok   = wr_en && CH_OK[wr_ch];
    rd_ok   = CH_OK[rd_ch];
    clr_ok  = clr_en && CH_OK[clr_ch];
    wr_circ = mode[wr_ch];
    rd_circ = mode[rd_ch];
    wr_clr  = clr_ok && clr_ch == wr_ch;
    // A same-cycle flush rewinds the write to slot 0 of an empty line
    wr_pa   = wr_circ ? (wr_clr ? '0 : head[wr_ch]) : wr_addr;
    wr_fill = wr_clr ? (ADDR_W + 1)'(1) : fill[wr_ch] == FULL_FILL ? fill[wr_ch] : fill[wr_ch] + 1'b1;
    rd_pa   = rd_circ ? head[rd_ch] - 1'b1 - rd_addr : rd_addr;
`ifdef FIR_DELAY_RF_WR_FWD_EN
    rd_zero = rd_circ && {1'b0, rd_addr} >= (wr_ok && wr_ch == rd_ch && wr_circ ? wr_fill : fill[rd_ch]);
    rd_word = !rd_ok || rd_zero ? '0 : wr_ok && wr_ch == rd_ch && wr_pa == rd_pa ? wr_data : mem[{rd_ch, rd_pa}];
`else
    rd_zero = rd_circ && {1'b0, rd_addr} >= fill[rd_ch];
    rd_word = !rd_ok || rd_zero ? '0 : mem[{rd_ch, rd_pa}];
`endif
  end
  always_ff @(posedge clk2) if (wr_ok) mem[{wr_ch, wr_pa}] <= wr_data;
  always_ff @(posedge clk2) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      full     <= '0;
      for (int c = 0; c < NCH; c++) begin
        head[c] <= '0;
        fill[c] <= '0;
      end
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_word;
      for (int c = 0; c < NCH; c++) begin
        if (wr_ok && wr_circ && wr_ch == CH_W'(c)) begin
          head[c] <= wr_pa + 1'b1;
          fill[c] <= wr_fill;
          full[c] <= wr_fill == FULL_FILL;
        end else if (clr_ok && clr_ch == CH_W'(c)) begin
          head[c] <= '0;
          fill[c] <= '0;
          full[c] <= 1'b0;
        end
      end
    end
  end
endmodule
